dmem_burst_ctrl: RTL and testbench
==================================

DMEM_BURST_CTRL -- requirements
Module: dmem_burst_ctrl

Interface
REQ-001 SHALL use `DMEM_ADDR_WIDTH, default 8 (bench), as the data memory word-address width.
REQ-002 SHALL use `DATA_WIDTH, default 32 (bench), as the data word width.
REQ-003 SHALL provide parameter LEN_W, default 8, as the burst-length field width.
REQ-004 clk  in  1  single clock for all logic, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid / cmd_ready  in / out  1  command handshake.
REQ-007 cmd_we  in  1  burst direction: 1 = write, 0 = read.
REQ-008 cmd_addr  in  `DMEM_ADDR_WIDTH  burst start word address.
REQ-009 cmd_len  in  LEN_W  burst length minus 1 (0 = one word).
REQ-010 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / `DATA_WIDTH  write-data stream.
REQ-011 rd_valid / rd_ready / rd_data / rd_last  out / in / out / out  1 / 1 / `DATA_WIDTH / 1  read-data stream.
REQ-012 mem_addr / mem_din / mem_we  out  `DMEM_ADDR_WIDTH / `DATA_WIDTH / 1  drives one port of the synchronous-read data memory.
REQ-013 mem_dout  in  `DATA_WIDTH  memory read data, valid one cycle after the address edge.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clk edge with cmd_valid&cmd_ready, capturing addr, len, and we.
REQ-017 On acceptance the state SHALL go to WRITE if cmd_we=1, else READ; the word counter SHALL load 0.
REQ-018 WRITE: wr_ready=1; each wr_valid&wr_ready cycle SHALL assert mem_we combinationally with mem_addr=base+count and mem_din=wr_data, then increment count.
REQ-019 WRITE SHALL return to IDLE on the beat where count==len; mem_we SHALL be 0 on every cycle without a write beat.
REQ-020 READ: a read SHALL be issued (mem_addr=base+count, mem_we=0) only when response-buffer occupancy plus in-flight reads is < 2.
REQ-021 The returning mem_dout SHALL be captured into a 2-entry response FIFO exactly one cycle after issue, tagged last if it was word len.
REQ-022 After issuing word len, the state SHALL go to DRAIN; DRAIN SHALL go to IDLE when the FIFO is empty and no read is in flight.
REQ-023 rd_valid SHALL equal FIFO-not-empty; rd_data/rd_last SHALL come from the FIFO head and hold stable while rd_valid&!rd_ready.
REQ-024 A simultaneous FIFO push and pop SHALL keep occupancy unchanged with order preserved; with rd_ready held 1 reads SHALL stream one word per cycle.
REQ-025 Address arithmetic SHALL be modulo 2^`DMEM_ADDR_WIDTH (wrap from max to 0); the count SHALL be LEN_W bits and never exceed len.
REQ-026 Max burst SHALL be 2^LEN_W words; no write or read SHALL be issued outside the accepted burst.
REQ-027 When idle, mem_addr SHALL hold the last driven value and mem_we SHALL be 0.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, count 0, FIFO empty, in-flight flag 0, and rd_valid=0, mem_we=0, busy=0, rd_last=0, mem_addr=0, and cmd_ready=1 (on rst deassertion).
REQ-029 Reset mid-burst SHALL abandon the burst with no further memory writes; a return from an issued read SHALL be discarded.

Verification
REQ-030 Write burst: addr=0x10, len=3, data 0xA0..0xA3 back-to-back -> mem writes at 0x10..0x13 on 4 consecutive cycles, busy drops the next cycle.
REQ-031 Read burst, rd_ready=1: addr=0x10, len=3 -> rd_data 0xA0..0xA3 on 4 consecutive cycles, first 2 cycles after accept, rd_last only on 0xA3.
REQ-032 Backpressure: same read with rd_ready toggling 1,0,0,1,... -> no lost/duplicated word, data held while stalled, at most 2 reads outstanding.
REQ-033 Wrap: write addr=0xFE, len=2, data 1,2,3 -> mem[0xFE]=1, mem[0xFF]=2, mem[0x00]=3.
REQ-034 Gapped write: wr_valid low 3 cycles mid-burst -> mem_we=0 during the gap, count holds, burst completes correctly.
REQ-035 Reset mid-read: rst pulse after 2 of 4 words -> rd_valid=0 immediately, busy=0, cmd_ready=1 after release, and a new command is accepted normally.

Source files
------------

// File: rtl/dmem_burst_ctrl_if.sv
// Bundle of the command, write-data, read-data and memory-port signals of
// the data-memory burst controller. The controller sits on the slave side;
// the requester plus the memory sit on the master side.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface dmem_burst_ctrl_if #(
    parameter int LEN_W = 8
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic                        cmd_we;
    logic [`DMEM_ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_W-1:0]            cmd_len;

    logic                        wr_valid;
    logic                        wr_ready;
    logic [`DATA_WIDTH-1:0]      wr_data;

    logic                        rd_valid;
    logic                        rd_ready;
    logic [`DATA_WIDTH-1:0]      rd_data;
    logic                        rd_last;

    logic [`DMEM_ADDR_WIDTH-1:0] mem_addr;
    logic [`DATA_WIDTH-1:0]      mem_din;
    logic                        mem_we;
    logic [`DATA_WIDTH-1:0]      mem_dout;

    logic                        busy;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, mem_dout,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
        input  mem_addr, mem_din, mem_we, busy
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, mem_dout,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last,
        output mem_addr, mem_din, mem_we, busy
    );
endinterface

// File: rtl/dmem_burst_ctrl.sv
// Burst controller for one port of a synchronous-read data memory.
// Write bursts pass the write stream straight to the memory port; read
// bursts issue at most two outstanding reads into a 2-entry response FIFO
// so a stalled consumer never loses data and a ready one streams 1 word/cycle.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dmem_burst_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    dmem_burst_ctrl_if.slave  bus
);
    localparam int AW = `DMEM_ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t           state;
    logic [AW-1:0]    base;
    logic [AW-1:0]    last_addr;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic             inflight;
    logic             inflight_last;

    logic [DW-1:0]    fifo_data [2];
    logic [1:0]       fifo_last;
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       occ;

    logic [AW-1:0]    cur_addr;
    logic             cnt_end;
    logic             wr_beat;
    logic             rd_issue;
    logic             push;
    logic             pop;
    logic [1:0]       occ_after_pop;

    // Address arithmetic wraps naturally at the address width.
    assign cur_addr = base + AW'(cnt);
    assign cnt_end  = (cnt == len);
    assign wr_beat  = (state == WRITE) && bus.wr_valid;

    // The response of a read issued last cycle lands in the FIFO this cycle.
    assign push          = inflight;
    assign pop           = (occ != 2'd0) && bus.rd_ready;
    assign occ_after_pop = occ - {1'b0, pop};
    // Crediting this cycle's pop keeps the pipe full when rd_ready stays high.
    assign rd_issue      = (state == READ) && ((occ_after_pop + {1'b0, inflight}) < 2'd2);

    assign bus.cmd_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.wr_ready  = (state == WRITE);
    assign bus.mem_we    = wr_beat;
    assign bus.mem_din   = bus.wr_data;
    assign bus.mem_addr  = (wr_beat || rd_issue) ? cur_addr : last_addr;
    assign bus.rd_valid  = (occ != 2'd0);
    assign bus.rd_data   = fifo_data[rd_ptr];
    assign bus.rd_last   = (occ != 2'd0) && fifo_last[rd_ptr];

    // Burst FSM: state, word counter, in-flight read tracking, held address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last_addr     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (wr_beat || rd_issue)
                last_addr <= cur_addr;
            inflight      <= rd_issue;
            inflight_last <= rd_issue && cnt_end;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state <= bus.cmd_we ? WRITE : READ;
                        cnt   <= '0;
                    end
                end
                WRITE: begin
                    if (wr_beat) begin
                        if (cnt_end) state <= IDLE;
                        else         cnt   <= cnt + LEN_W'(1);
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        if (cnt_end) state <= DRAIN;
                        else         cnt   <= cnt + LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if ((occ == 2'd0) && !inflight)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command capture: base address and length of the accepted burst.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.cmd_valid) begin
            base <= bus.cmd_addr;
            len  <= bus.cmd_len;
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Response FIFO storage: memory data plus its last-word tag.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= bus.mem_dout;
            fifo_last[wr_ptr] <= inflight_last;
        end
    end
endmodule

// File: tb/tb_dmem_burst_ctrl.sv
// Bench for dmem_burst_ctrl: synchronous-read memory model, write/read
// scoreboards filled when stimulus is driven and drained by monitors.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dmem_burst_ctrl;
    localparam int AW = `DMEM_ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [DW-1:0] data; logic last; } rd_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   rd_mode = 0;
    int   rd_seen = 0;
    int   acc;

    wr_t  exp_wr [$];
    rd_t  exp_rd [$];
    int   wr_cyc [$];
    int   rd_cyc [$];

    logic [DW-1:0] mem    [1<<AW];
    logic [DW-1:0] shadow [1<<AW];
    logic          stalled = 1'b0;
    logic [DW-1:0] held_data;

    dmem_burst_ctrl_if #(.LEN_W(8)) bus ();

    dmem_burst_ctrl #(.LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Synchronous-read memory on the controller's port.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    // Write monitor: every mem_we beat must match the next expected write.
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.mem_we) begin
            if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                e = exp_wr.pop_front();
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.mem_din, e.data);
            end
            wr_cyc.push_back(cyc);
        end
    end

    // Read monitor: stall holding and in-order delivery of expected words.
    always @(negedge clk) begin
        rd_t r;
        if (!rst) begin
            if (stalled) begin
                check("rd_hold_valid", bus.rd_valid, 1);
                check("rd_hold_data", bus.rd_data, held_data);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    r = exp_rd.pop_front();
                    check("rd_data", bus.rd_data, r.data);
                    check("rd_last", bus.rd_last, r.last);
                end
                rd_cyc.push_back(cyc);
                rd_seen++;
            end
            stalled   = bus.rd_valid && !bus.rd_ready;
            held_data = bus.rd_data;
        end else begin
            stalled = 1'b0;
        end
    end

    // Consumer: rd_ready always high (mode 0) or pattern 1,0,0 (mode 1).
    initial begin
        int ph = 0;
        bus.rd_ready = 1'b1;
        forever begin
            @(posedge clk); #2;
            if (rd_mode == 0) bus.rd_ready = 1'b1;
            else begin
                bus.rd_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [7:0] len,
                          output int acc_cyc);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.cmd_valid = 1'b0;
        if (!we)
            for (int i = 0; i <= int'(len); i++)
                exp_rd.push_back({shadow[addr + AW'(i)], (i == int'(len))});
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int len, input logic [DW-1:0] d0,
                               input int gap_at, input int gap_len, output int acc_cyc);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        do_cmd(1'b1, addr, 8'(len), acc_cyc);
        for (int i = 0; i <= len; i++) begin
            if (i == gap_at) begin
                bus.wr_valid = 1'b0;
                repeat (gap_len) begin
                    @(negedge clk);
                    check("gap_mem_we", bus.mem_we, 0);
                    @(posedge clk); #1;
                end
            end
            a = addr + AW'(i);
            d = d0 + DW'(i);
            bus.wr_valid = 1'b1;
            bus.wr_data  = d;
            exp_wr.push_back({a, d});
            shadow[a] = d;
            check("wr_ready", bus.wr_ready, 1);
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("wr_busy_drop", bus.busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rd_done();
        int n = 0;
        while ((exp_rd.size() != 0 || bus.busy) && n < 200) begin @(negedge clk); #1; n++; end
        check("rd_done_timeout", n < 200, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin mem[i] = '0; shadow[i] = '0; end
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_rd_last", bus.rd_last, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);

        // Back-to-back write burst at 0x10.
        wr_cyc.delete();
        write_burst(8'h10, 3, 32'hA0, -1, 0, acc);
        check("wr_beats", wr_cyc.size(), 4);
        check("wr_first_cyc", wr_cyc[0], acc);
        check("wr_last_cyc", wr_cyc[3], acc + 3);

        // Streaming read of the same words.
        rd_mode = 0;
        rd_cyc.delete();
        do_cmd(1'b0, 8'h10, 8'd3, acc);
        wait_rd_done();
        check("rd_words", rd_cyc.size(), 4);
        check("rd_first_cyc", rd_cyc[0], acc + 2);
        check("rd_last_cyc", rd_cyc[3], acc + 5);

        // Same read under backpressure.
        rd_mode = 1;
        rd_cyc.delete();
        do_cmd(1'b0, 8'h10, 8'd3, acc);
        wait_rd_done();
        check("bp_words", rd_cyc.size(), 4);
        rd_mode = 0;

        // Address wrap.
        write_burst(8'hFE, 2, 32'd1, -1, 0, acc);
        check("wrap_mem_fe", mem[8'hFE], 1);
        check("wrap_mem_ff", mem[8'hFF], 2);
        check("wrap_mem_00", mem[8'h00], 3);
        do_cmd(1'b0, 8'hFE, 8'd2, acc);
        wait_rd_done();

        // Gapped write, read back under backpressure.
        write_burst(8'h40, 3, 32'hB0, 2, 3, acc);
        rd_mode = 1;
        do_cmd(1'b0, 8'h40, 8'd3, acc);
        wait_rd_done();
        rd_mode = 0;

        // Reset in the middle of a read burst.
        rd_seen = 0;
        do_cmd(1'b0, 8'h10, 8'd3, acc);
        for (int n = 0; n < 50 && rd_seen < 2; n++) begin @(negedge clk); #1; end
        check("mid_rd_seen", rd_seen, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_rd_valid", bus.rd_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_mem_we", bus.mem_we, 0);
        exp_rd.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_cmd_ready", bus.cmd_ready, 1);
        rd_cyc.delete();
        do_cmd(1'b0, 8'h40, 8'd1, acc);
        wait_rd_done();
        check("post_rst_words", rd_cyc.size(), 2);

        check("exp_wr_empty", exp_wr.size(), 0);
        check("exp_rd_empty", exp_rd.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
